ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the shared PS2_CLK/PS2_DATA lines.
- It is the opposite direction of the existing keyboard receive path and sits beside the keyboard unit under pong_top.
- It drives the lines open-drain: each output only ever requests "pull low".
- It runs the full request-to-send sequence: clock inhibit, start, data, parity, stop, then the device ACK.

---
 rtl/ps2_host_tx_if.sv | 53 +++++
 rtl/ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Purpose : bundles the command handshake and the PS/2 pin signals of the
//           host-to-device PS/2 transmitter into one port.
// Latency : n/a (wires only).
// Backpressure: busy is the only flow control; tx_start is dropped while busy=1.
//
// Signals:
//   tx_start           one-cycle request; tx_data is captured on the same cycle
//   tx_data[7:0]       command byte to send
//   busy               high from acceptance until tx_done/tx_err
//   tx_done            one-cycle pulse: device ACK seen and lines back to idle
//   tx_err             one-cycle pulse: NACK or timeout
//   ps2_clk_in         raw PS2_CLK pin level
//   ps2_data_in        raw PS2_DATA pin level
//   ps2_clk_drive_low  1 = pull PS2_CLK low, 0 = release (open drain)
//   ps2_data_drive_low 1 = pull PS2_DATA low, 0 = release (open drain)
//
// The slave modport is the transmitter itself; the master modport is its
// surroundings (command source plus the physical pins).
interface ps2_host_tx_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       tx_done;
   logic       tx_err;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_drive_low;
   logic       ps2_data_drive_low;

   modport master (
      output tx_start,
      output tx_data,
      output ps2_clk_in,
      output ps2_data_in,
      input  busy,
      input  tx_done,
      input  tx_err,
      input  ps2_clk_drive_low,
      input  ps2_data_drive_low
   );

   modport slave (
      input  tx_start,
      input  tx_data,
      input  ps2_clk_in,
      input  ps2_data_in,
      output busy,
      output tx_done,
      output tx_err,
      output ps2_clk_drive_low,
      output ps2_data_drive_low
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Purpose : host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB
//           first, odd parity, stop, then waits for the device ACK.
// Latency : data line updates 1 clk after the filtered PS2_CLK fall strobe;
//           a whole command takes INHIBIT_CYCLES plus 11 device clocks.
// Backpressure: one command at a time; tx_start while busy=1 is dropped.
//
// Ports:
//   clk    system clock (100 MHz)
//   reset  synchronous, active-high; releases both lines on the next edge
//   bus    ps2_host_tx_if.slave: tx_start/tx_data in, busy/tx_done/tx_err out,
//          raw PS/2 pin levels in, open-drain pull-low requests out
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int FILTER_LEN     = 8
) (
   input  logic         clk,
   input  logic         reset,
   ps2_host_tx_if.slave bus
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);

   // Last inhibit cycle, and the cycle before it (where the start bit is
   // asserted so that it is already on the wire in the final inhibit cycle).
   localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
   localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RELEASE,
      SHIFT,
      ACK,
      WAIT_IDLE
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic             clk_meta;
   logic             clk_sync;
   logic             data_meta;
   logic             data_sync;
   logic             clk_filt;
   logic             clk_filt_d;
   logic [FLT_W-1:0] flt_cnt;
   logic             fall;

   // Idle bus level is high, so the synchronizers and filter come out of
   // reset at 1 and no spurious fall is seen after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta   <= 1'b1;
         clk_sync   <= 1'b1;
         data_meta  <= 1'b1;
         data_sync  <= 1'b1;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         flt_cnt    <= '0;
      end else begin
         clk_meta   <= bus.ps2_clk_in;
         clk_sync   <= clk_meta;
         data_meta  <= bus.ps2_data_in;
         data_sync  <= data_meta;
         clk_filt_d <= clk_filt;
         // Count consecutive samples that disagree with the accepted level;
         // any agreeing sample restarts the run, so short glitches vanish.
         if (clk_sync == clk_filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_LAST) begin
            clk_filt <= clk_sync;
            flt_cnt  <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign fall = clk_filt_d & ~clk_filt;

   // ------------------------------------------------------------------
   // Transmit state machine
   // ------------------------------------------------------------------
   state_t           state;
   state_t           state_nxt;
   logic [7:0]       shreg;
   logic [7:0]       shreg_nxt;
   logic             parity;
   logic             parity_nxt;
   logic [3:0]       bit_cnt;
   logic [3:0]       bit_cnt_nxt;
   logic [INH_W-1:0] inh_cnt;
   logic [INH_W-1:0] inh_cnt_nxt;
   logic [TO_W-1:0]  to_cnt;
   logic [TO_W-1:0]  to_cnt_nxt;
   logic             busy;
   logic             busy_nxt;
   logic             done;
   logic             done_nxt;
   logic             err;
   logic             err_nxt;
   logic             clk_dl;
   logic             clk_dl_nxt;
   logic             data_dl;
   logic             data_dl_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         parity  <= 1'b0;
         bit_cnt <= '0;
         inh_cnt <= '0;
         to_cnt  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         clk_dl  <= 1'b0;
         data_dl <= 1'b0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         parity  <= parity_nxt;
         bit_cnt <= bit_cnt_nxt;
         inh_cnt <= inh_cnt_nxt;
         to_cnt  <= to_cnt_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         clk_dl  <= clk_dl_nxt;
         data_dl <= data_dl_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      parity_nxt  = parity;
      bit_cnt_nxt = bit_cnt;
      inh_cnt_nxt = inh_cnt;
      to_cnt_nxt  = to_cnt;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      clk_dl_nxt  = clk_dl;
      data_dl_nxt = data_dl;

      case (state)
         IDLE: begin
            clk_dl_nxt  = 1'b0;
            data_dl_nxt = 1'b0;
            if (bus.tx_start) begin
               shreg_nxt   = bus.tx_data;
               parity_nxt  = ~^bus.tx_data;   // odd parity over 9 bits
               busy_nxt    = 1'b1;
               inh_cnt_nxt = '0;
               clk_dl_nxt  = 1'b1;
               state_nxt   = INHIBIT;
            end
         end

         INHIBIT: begin
            inh_cnt_nxt = inh_cnt + 1'b1;
            if (inh_cnt == INH_START) begin
               data_dl_nxt = 1'b1;
            end
            if (inh_cnt == INH_LAST) begin
               clk_dl_nxt  = 1'b0;
               data_dl_nxt = 1'b1;
               state_nxt   = RELEASE;
            end
         end

         RELEASE: begin
            bit_cnt_nxt = '0;
            to_cnt_nxt  = '0;
            state_nxt   = SHIFT;
         end

         SHIFT: begin
            // Timeout is tested first so it wins over a coincident fall.
            if (to_cnt == TO_LIMIT) begin
               clk_dl_nxt  = 1'b0;
               data_dl_nxt = 1'b0;
               err_nxt     = 1'b1;
               busy_nxt    = 1'b0;
               state_nxt   = IDLE;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
               if (fall) begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                     data_dl_nxt = ~shreg[bit_cnt[2:0]];
                  end else if (bit_cnt == 4'd8) begin
                     data_dl_nxt = ~parity;
                  end else begin
                     // Stop bit is the released line; device ACK follows.
                     data_dl_nxt = 1'b0;
                     state_nxt   = ACK;
                  end
               end
            end
         end

         ACK: begin
            if (to_cnt == TO_LIMIT) begin
               clk_dl_nxt  = 1'b0;
               data_dl_nxt = 1'b0;
               err_nxt     = 1'b1;
               busy_nxt    = 1'b0;
               state_nxt   = IDLE;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
               if (fall) begin
                  if (!data_sync) begin
                     state_nxt = WAIT_IDLE;
                  end else begin
                     err_nxt   = 1'b1;
                     busy_nxt  = 1'b0;
                     state_nxt = IDLE;
                  end
               end
            end
         end

         WAIT_IDLE: begin
            if (clk_filt && data_sync) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end

         default: begin
            clk_dl_nxt  = 1'b0;
            data_dl_nxt = 1'b0;
            busy_nxt    = 1'b0;
            state_nxt   = IDLE;
         end
      endcase
   end

   assign bus.busy               = busy;
   assign bus.tx_done            = done;
   assign bus.tx_err             = err;
   assign bus.ps2_clk_drive_low  = clk_dl;
   assign bus.ps2_data_drive_low = data_dl;

endmodule
